dec16: RTL and testbench

DEC16 -- requirements
Module: dec16

---
 rtl/dec16.sv | 117 +++++++++++
 tb/tb_dec16.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec16.sv
// dec16: loadable down-counter with a one-cycle completion pulse.
//
// A start value is accepted in IDLE. The block then decrements once per enabled
// cycle in COUNT, passes through DONE for exactly one cycle, and returns to IDLE.
// An abort in COUNT returns to IDLE, keeps the count, and does not pulse done.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   load_valid_i  a start value is offered
//   load_data_i   start value (WIDTH bits)
//   load_ready_o  high in IDLE only (decoded from the state register)
//   en_i          decrement enable, used in COUNT only
//   abort_i       cancels a countdown, used in COUNT only
//   count_o       registered current count
//   busy_o        high while in COUNT
//   zero_o        count_o == 0
//   done_o        high for the single cycle spent in DONE
module dec16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  input  logic             en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             zero_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             load_fire;

  // Handshake only exists in IDLE, so ready is a pure state decode.
  assign load_fire = load_valid_i && (state_q == ST_IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          count_d = load_data_i;
          state_d = (load_data_i == '0) ? ST_DONE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort wins over enable; count is left as it stands.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (en_i) begin
          // Exit at 1 -> 0 so the counter never wraps.
          if (count_q == WIDTH'(1)) begin
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and count only.
  always_comb begin
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    count_o      = count_q;
    zero_o       = (count_q == '0);
    unique case (state_q)
      ST_IDLE:  load_ready_o = 1'b1;
      ST_COUNT: busy_o       = 1'b1;
      ST_DONE:  done_o       = 1'b1;
      default:  load_ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dec16.sv
// tb_dec16: directed vector table, hand-written reset sequences, and a random
// run checked against a behavioural countdown model.
module tb_dec16;

  localparam int unsigned WIDTH = 16;

  logic             clk_i;
  logic             rst_ni;
  logic             load_valid_i;
  logic [WIDTH-1:0] load_data_i;
  logic             load_ready_o;
  logic             en_i;
  logic             abort_i;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             zero_o;
  logic             done_o;

  int n_vec;
  int n_err;

  dec16 #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .en_i         (en_i),
    .abort_i      (abort_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .zero_o       (zero_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             lv;
    logic [WIDTH-1:0] data;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] exp_count;
    logic             exp_busy;
    logic             exp_done;
    logic             exp_ready;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic lv, input int data, input logic en, input logic abort,
                     input int exp_count, input logic exp_busy, input logic exp_done,
                     input logic exp_ready);
    vec_t v;
    v.lv        = lv;
    v.data      = WIDTH'(data);
    v.en        = en;
    v.abort     = abort;
    v.exp_count = WIDTH'(exp_count);
    v.exp_busy  = exp_busy;
    v.exp_done  = exp_done;
    v.exp_ready = exp_ready;
    tbl.push_back(v);
  endtask

  task automatic check1(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] e_cnt,
                           input logic e_busy, input logic e_done, input logic e_ready);
    check1({tag, ".count"}, count_o, e_cnt);
    check1({tag, ".zero"},  WIDTH'(zero_o),       WIDTH'(e_cnt == '0));
    check1({tag, ".busy"},  WIDTH'(busy_o),       WIDTH'(e_busy));
    check1({tag, ".done"},  WIDTH'(done_o),       WIDTH'(e_done));
    check1({tag, ".ready"}, WIDTH'(load_ready_o), WIDTH'(e_ready));
  endtask

  task automatic drive(input logic lv, input logic [WIDTH-1:0] d, input logic en,
                       input logic ab);
    load_valid_i = lv;
    load_data_i  = d;
    en_i         = en;
    abort_i      = ab;
  endtask

  // Behavioural model: phase 0 idle, 1 counting, 2 completion cycle.
  int          m_phase;
  int unsigned m_cnt;
  int unsigned m_loaded;
  int unsigned m_en_seen;
  bit          m_from_load;

  task automatic model_step(input logic lv, input logic [WIDTH-1:0] d, input logic en,
                            input logic ab);
    case (m_phase)
      0: if (lv) begin
        m_cnt       = d;
        m_loaded    = d;
        m_en_seen   = 0;
        m_from_load = 1;
        m_phase     = (d == 0) ? 2 : 1;
      end
      1: if (ab) begin
        m_phase = 0;
      end else if (en) begin
        m_en_seen++;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    string tag;
    logic [WIDTH-1:0] rd;
    logic rlv, ren, rab;
    n_vec = 0;
    n_err = 0;

    // Reset state before any clock edge.
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check_all("reset", '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset_held", '0, 1'b0, 1'b0, 1'b1);
    rst_ni = 1'b1;

    //   lv data     en ab  count   busy done ready
    // Load 3, enable held (first edge after reset release accepts the load).
    add(1, 3,        1, 0, 3,       1, 0, 0);
    add(0, 0,        1, 0, 2,       1, 0, 0);
    add(0, 0,        1, 0, 1,       1, 0, 0);
    add(0, 0,        1, 0, 0,       0, 1, 0);
    add(0, 0,        1, 0, 0,       0, 0, 1);
    // Load 0 goes straight to the completion cycle.
    add(1, 0,        1, 0, 0,       0, 1, 0);
    add(0, 0,        0, 0, 0,       0, 0, 1);
    // Load 5, enable toggled.
    add(1, 5,        0, 0, 5,       1, 0, 0);
    add(0, 0,        1, 0, 4,       1, 0, 0);
    add(0, 0,        0, 0, 4,       1, 0, 0);
    add(0, 0,        1, 0, 3,       1, 0, 0);
    add(0, 0,        0, 0, 3,       1, 0, 0);
    add(0, 0,        0, 1, 3,       0, 0, 1);
    // Load 10, two decrements, abort with enable.
    add(1, 10,       0, 0, 10,      1, 0, 0);
    add(0, 0,        1, 0, 9,       1, 0, 0);
    add(0, 0,        1, 0, 8,       1, 0, 0);
    add(0, 0,        1, 1, 8,       0, 0, 1);
    // Idle ignores enable.
    add(0, 0,        1, 0, 8,       0, 0, 1);
    // Max value, second load ignored during count.
    add(1, 'hFFFF,   0, 0, 'hFFFF,  1, 0, 0);
    add(1, 1,        0, 0, 'hFFFF,  1, 0, 0);
    add(1, 1,        1, 0, 'hFFFE,  1, 0, 0);
    add(0, 0,        0, 1, 'hFFFE,  0, 0, 1);
    // Abort ignored in idle.
    add(0, 0,        0, 1, 'hFFFE,  0, 0, 1);
    // Load 1; abort and load offered during the completion cycle are ignored.
    add(1, 1,        0, 0, 1,       1, 0, 0);
    add(0, 0,        1, 0, 0,       0, 1, 0);
    add(1, 7,        1, 1, 0,       0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].lv, tbl[i].data, tbl[i].en, tbl[i].abort);
      @(posedge clk_i);
      #1;
      tag = $sformatf("vec%0d", i);
      check_all(tag, tbl[i].exp_count, tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_ready);
    end

    // Async reset mid-countdown: load 4, two decrements, reset between edges.
    drive(1'b1, WIDTH'(4), 1'b1, 1'b0);
    @(posedge clk_i); #1;
    check_all("rst_cnt_load", WIDTH'(4), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    check_all("rst_cnt_d1", WIDTH'(3), 1'b1, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    check_all("rst_cnt_d2", WIDTH'(2), 1'b1, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_all("rst_cnt_async", '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    check_all("rst_cnt_hold", '0, 1'b0, 1'b0, 1'b1);
    rst_ni = 1'b1;

    // Async reset during the completion cycle drops the pulse.
    drive(1'b1, WIDTH'(1), 1'b1, 1'b0);
    @(posedge clk_i); #1;
    check_all("rst_done_load", WIDTH'(1), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    check_all("rst_done_pulse", '0, 1'b0, 1'b1, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_all("rst_done_async", '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    check_all("rst_done_after", '0, 1'b0, 1'b0, 1'b1);
    rst_ni = 1'b1;

    // Random run against the model, starting from reset state.
    m_phase     = 0;
    m_cnt       = 0;
    m_loaded    = 0;
    m_en_seen   = 0;
    m_from_load = 0;
    for (int c = 0; c < 3000; c++) begin
      rlv = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 40) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
      ren = ($urandom_range(0, 3) != 0);
      rab = ($urandom_range(0, 24) == 0);
      drive(rlv, rd, ren, rab);
      @(posedge clk_i);
      model_step(rlv, rd, ren, rab);
      #1;
      tag = $sformatf("rnd%0d", c);
      check_all(tag, WIDTH'(m_cnt), m_phase == 1, m_phase == 2, m_phase == 0);
      // A completed countdown needed exactly N enabled cycles after the load edge.
      if (m_phase == 2 && m_from_load) begin
        check1({tag, ".latency"}, WIDTH'(m_en_seen), WIDTH'(m_loaded));
        m_from_load = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
